rom_arbiter: RTL and testbench

//  Round-robin arbiter sharing one SDRAM ROM read port between N read-only requesters.

---
 rtl/rom_arbiter.sv | 130 +++++++++++++
 tb/tb_rom_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
//------------------------------------------------------------------------------
// Module  : rom_arbiter
// Brief   : Round-robin arbiter sharing one SDRAM ROM read port between N
//           read-only clients; optional WAIT watchdog via ROM_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rom_arbiter #(
    parameter int N       = 3,
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic [N*ADDR_W-1:0]   addr,
    output logic [N-1:0]          valid,
    output logic [DATA_W-1:0]     data,
    output logic [N-1:0]          grant,
    output logic                  sdram_req,
    output logic [ADDR_W-1:0]     sdram_addr,
    input  logic                  sdram_valid,
    input  logic [DATA_W-1:0]     sdram_data,
    output logic                  timeout_err
);

    localparam int LW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t        state;
    logic [LW-1:0] last;
    logic [LW-1:0] pick;
    logic [N-1:0]  pick_oh;
    logic          any_req;
    logic          wdog_hit;

    generate
        if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_param_check
            $error("rom_arbiter: parameter out of range");
        end
    endgenerate

    // Scan last+1, last+2, ... so the client served most recently ranks lowest.
    always_comb begin
        pick    = last;
        any_req = 1'b0;
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = int'(last) + i;
            if (idx >= N) idx = idx - N;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                pick    = idx[LW-1:0];
            end
        end
        pick_oh       = '0;
        pick_oh[pick] = 1'b1;
    end

    // Read data passes straight through; a client whose req dropped gets no valid.
    assign valid = (state == S_WAIT && sdram_valid) ? (grant & req) : '0;
    assign data  = (state == S_WAIT) ? sdram_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            grant      <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            last       <= LW'(N - 1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant      <= pick_oh;
                        sdram_addr <= addr[int'(pick)*ADDR_W +: ADDR_W];
                        sdram_req  <= 1'b1;
                        last       <= pick;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sdram_valid || wdog_hit) begin
                        sdram_req <= 1'b0;
                        state     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    grant <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ROM_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

    logic [WW-1:0] wdog;

    // wdog holds the number of WAIT cycles already spent; the TIMEOUT-th one aborts.
    assign wdog_hit = (state == S_WAIT) && !sdram_valid && (wdog == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_WAIT) wdog <= wdog + 1'b1;
            else                 wdog <= '0;
            if (wdog_hit) timeout_err <= 1'b1;
        end
    end
`else
    assign wdog_hit    = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_rom_arbiter
// Brief   : Directed, scoreboard-based bench for rom_arbiter (N=3, TIMEOUT=8).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rom_arbiter;

    localparam int N = 3;
    localparam int AW = 24;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]  valid;
    logic [DW-1:0] data;
    logic [N-1:0]  grant;
    logic          sdram_req;
    logic [AW-1:0] sdram_addr;
    logic          sdram_valid;
    logic [DW-1:0] sdram_data;
    logic          timeout_err;

    typedef struct {
        logic [N-1:0]  v;
        logic [DW-1:0] d;
    } sb_t;

    sb_t sbq[$];
    int  total = 0;
    int  bad   = 0;
    int  rr_last;

    rom_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .valid(valid),
        .data(data), .grant(grant), .sdram_req(sdram_req),
        .sdram_addr(sdram_addr), .sdram_valid(sdram_valid),
        .sdram_data(sdram_data), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input int l);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (l + k) % N;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    task automatic wait_grant();
        for (int k = 0; k < 10; k++) begin
            if (sdram_req) break;
            step();
        end
        chk("grant_wait", {31'b0, sdram_req}, 32'd1);
    endtask

    // One complete service: grant check, WAIT of lat cycles, data return, RELEASE, IDLE.
    task automatic serve(input logic drop_in_wait, input logic [DW-1:0] d, input int lat);
        int           p;
        logic [N-1:0] oh;
        logic [AW-1:0] a;
        sb_t          e;
        wait_grant();
        p  = model_pick(req, rr_last);
        oh = '0;
        oh[p] = 1'b1;
        a  = addr[p*AW +: AW];
        chk("grant", {29'b0, grant}, {29'b0, oh});
        chk("sdram_addr", {8'b0, sdram_addr}, {8'b0, a});
        rr_last = p;
        for (int k = 1; k < lat; k++) begin
            if (drop_in_wait && k == 1) req[p] = 1'b0;
            step();
        end
        sdram_valid = 1'b1;
        sdram_data  = d;
        e.v = req[p] ? oh : '0;
        e.d = d;
        sbq.push_back(e);
        #1;
        e = sbq.pop_front();
        chk("valid", {29'b0, valid}, {29'b0, e.v});
        chk("data", {16'b0, data}, {16'b0, e.d});
        chk("addr_stable", {8'b0, sdram_addr}, {8'b0, a});
        step();
        sdram_valid = 1'b0;
        sdram_data  = '0;
        req[p]      = 1'b0;
        chk("release_sdram_req", {31'b0, sdram_req}, 32'd0);
        step();
        chk("idle_grant", {29'b0, grant}, 32'd0);
        chk("idle_sdram_req", {31'b0, sdram_req}, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        req         = '0;
        sdram_valid = 1'b0;
        sdram_data  = '0;
        addr[0*AW +: AW] = 24'h000100;
        addr[1*AW +: AW] = 24'h0A0B0C;
        addr[2*AW +: AW] = 24'hFFFFFE;
        rr_last = N - 1;
        step();
        step();
        chk("rst_grant", {29'b0, grant}, 32'd0);
        chk("rst_sdram_req", {31'b0, sdram_req}, 32'd0);
        chk("rst_sdram_addr", {8'b0, sdram_addr}, 32'd0);
        chk("rst_valid", {29'b0, valid}, 32'd0);
        chk("rst_data", {16'b0, data}, 32'd0);
        chk("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
        reset = 1'b0;
        step();

        // 1: single client, one-cycle request-to-sdram_req latency
        req = 3'b001;
        step();
        chk("latency", {31'b0, sdram_req}, 32'd1);
        serve(1'b0, 16'hBEEF, 4);

        // 2: all three request from reset -> 0,1,2 then idle
        reset = 1'b1;
        step();
        reset = 1'b0;
        rr_last = N - 1;
        req = 3'b111;
        serve(1'b0, 16'h1111, 1);
        serve(1'b0, 16'h2222, 2);
        serve(1'b0, 16'h3333, 1);
        step();
        step();
        chk("drained_sdram_req", {31'b0, sdram_req}, 32'd0);
        chk("drained_grant", {29'b0, grant}, 32'd0);

        // 3: last=1, then 0 and 1 request -> pointer wraps, 0 first
        req = 3'b010;
        serve(1'b0, 16'h0101, 1);
        req = 3'b011;
        serve(1'b0, 16'h0A0A, 2);
        serve(1'b0, 16'h0B0B, 1);

        // 4: client 2 abandons during WAIT; client 0 pending behind it
        req = 3'b101;
        serve(1'b1, 16'h1234, 3);
        serve(1'b0, 16'h5678, 1);

        // 5: reset mid-WAIT, late sdram_valid ignored
        req = 3'b010;
        wait_grant();
        step();
        step();
        reset = 1'b1;
        req   = '0;
        step();
        reset = 1'b0;
        rr_last = N - 1;
        chk("rstwait_sdram_req", {31'b0, sdram_req}, 32'd0);
        chk("rstwait_grant", {29'b0, grant}, 32'd0);
        sdram_valid = 1'b1;
        sdram_data  = 16'hDEAD;
        #1;
        chk("late_valid", {29'b0, valid}, 32'd0);
        chk("late_data", {16'b0, data}, 32'd0);
        step();
        sdram_valid = 1'b0;
        sdram_data  = '0;
        chk("late_grant", {29'b0, grant}, 32'd0);

        // 6: watchdog (or unbounded WAIT in the default build)
        req = 3'b001;
        wait_grant();
        chk("wd_grant", {29'b0, grant}, 32'd1);
        rr_last = 0;
`ifdef ROM_ARB_TIMEOUT_EN
        begin
            int cnt;
            cnt = 0;
            for (int k = 0; k < 20; k++) begin
                if (!sdram_req) break;
                step();
                cnt++;
            end
            chk("wd_wait_cycles", cnt, 32'd8);
            chk("wd_timeout_err", {31'b0, timeout_err}, 32'd1);
            chk("wd_valid", {29'b0, valid}, 32'd0);
        end
        serve(1'b0, 16'hCAFE, 1);
        chk("wd_sticky", {31'b0, timeout_err}, 32'd1);
`else
        for (int k = 0; k < 20; k++) step();
        chk("wd_unbounded", {31'b0, sdram_req}, 32'd1);
        chk("wd_timeout_err", {31'b0, timeout_err}, 32'd0);
        serve(1'b0, 16'hCAFE, 1);
        chk("wd_still_zero", {31'b0, timeout_err}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
